// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared encodings for the multi-cycle ALU.
//   op_e    : op_sel encodings (ADD/SUB/MUL/DIV)
//   state_e : FSM states of alu_multicycle
package alu_mc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: one combinational iteration step on {acc, shreg}.
//   op        in  2      OP_MUL: shift-add step; OP_DIV: restoring-divide step
//                        (only when ALU_MC_DIV_EN is defined); others hold
//   acc       in  WIDTH  upper half (partial product / partial remainder)
//   shreg     in  WIDTH  lower half (multiplier bits / dividend -> quotient)
//   b         in  WIDTH  multiplicand / divisor
//   acc_nxt   out WIDTH  acc after the step
//   shreg_nxt out WIDTH  shreg after the step
// Build option: ALU_MC_DIV_EN adds the restoring-divide step.
module alu_mc_iter
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] shreg,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] shreg_nxt
);

  logic [WIDTH:0] sum;
`ifdef ALU_MC_DIV_EN
  logic [WIDTH:0] rem_t;
  logic [WIDTH:0] rem_d;
  logic           rem_ge;
`endif

  always_comb begin
    acc_nxt   = acc;
    shreg_nxt = shreg;
    // Shift-add: add b when the current multiplier LSB is set, then shift the
    // whole {carry, acc, shreg} right by one; the product fills shreg from the top.
    sum = {1'b0, acc} + (shreg[0] ? {1'b0, b} : '0);
`ifdef ALU_MC_DIV_EN
    // Restoring divide: bring in the next dividend bit, subtract b if it fits.
    // The partial remainder is always < b, so it fits back into WIDTH bits.
    rem_t  = {acc, shreg[WIDTH-1]};
    rem_d  = rem_t - {1'b0, b};
    rem_ge = (rem_t >= {1'b0, b});
`endif
    case (op)
      OP_MUL: begin
        acc_nxt   = sum[WIDTH:1];
        shreg_nxt = {sum[0], shreg[WIDTH-1:1]};
      end
`ifdef ALU_MC_DIV_EN
      OP_DIV: begin
        acc_nxt   = rem_ge ? rem_d[WIDTH-1:0] : rem_t[WIDTH-1:0];
        shreg_nxt = {shreg[WIDTH-2:0], rem_ge};
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: multi-cycle ADD/SUB/MUL(/DIV) ALU with valid/ready on both sides.
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake (op_a, op_b, op_sel)
//   out_valid/out_ready  result handshake (result, carry, zero, err)
//   result               2*WIDTH result; carry = ADD carry / SUB borrow
//   zero                 result == 0;  err = divide-by-zero or unsupported DIV
// Build option: ALU_MC_DIV_EN compiles in the restoring divider for op 11;
// without it op 11 finishes in one cycle with err=1, result=0.
//
// Timing: the accept edge only loads operands. Every op then passes through
// CALC: ADD/SUB/err cases finalize on the next edge (1-cycle latency),
// MUL/DIV iterate WIDTH times and finalize on the edge after (WIDTH+1).
module alu_multicycle
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic [1:0]         op_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               zero,
  output logic               err
);

  localparam int CNT_W = $clog2(WIDTH+1);

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   acc, shreg, b_q;
  logic [WIDTH-1:0]   acc_nxt, shreg_nxt;
  logic               accept, fire_out, iterative, finish;
  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] fin_res;
  logic               fin_carry, fin_err;

  assign accept   = in_valid && in_ready;
  assign fire_out = out_valid && out_ready;

`ifdef ALU_MC_DIV_EN
  assign iterative = (op_q == OP_MUL) || ((op_q == OP_DIV) && (b_q != '0));
`else
  assign iterative = (op_q == OP_MUL);
`endif
  assign finish = (state == CALC) && (!iterative || (cnt == CNT_W'(WIDTH)));

  alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
    .op        (op_q),
    .acc       (acc),
    .shreg     (shreg),
    .b         (b_q),
    .acc_nxt   (acc_nxt),
    .shreg_nxt (shreg_nxt)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = CALC;
      CALC:    if (finish)   state_nxt = DONE;
      DONE:    if (fire_out) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Final result; for ADD/SUB shreg still holds op_a (no iterations ran).
  always_comb begin
    fin_res   = '0;
    fin_carry = 1'b0;
    fin_err   = 1'b0;
    sum       = {1'b0, shreg} + {1'b0, b_q};
    diff      = {1'b0, shreg} - {1'b0, b_q};
    case (op_q)
      OP_ADD: begin
        fin_res   = {{(WIDTH-1){1'b0}}, sum};
        fin_carry = sum[WIDTH];
      end
      OP_SUB: begin
        fin_res   = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
        fin_carry = diff[WIDTH];  // borrow == (a < b)
      end
      OP_MUL: fin_res = {acc, shreg};
      default: begin
`ifdef ALU_MC_DIV_EN
        if (b_q == '0) begin
          fin_res = {shreg, {WIDTH{1'b1}}};  // remainder = a, quotient = all ones
          fin_err = 1'b1;
        end else begin
          fin_res = {acc, shreg};            // {remainder, quotient}
        end
`else
        fin_err = 1'b1;
`endif
      end
    endcase
  end

  // Datapath. result/flags are only written on finish, so a reset or an
  // in-flight operation never exposes a partial value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      op_q   <= '0;
      acc    <= '0;
      shreg  <= '0;
      b_q    <= '0;
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      err    <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      op_q  <= op_sel;
      acc   <= '0;
      shreg <= op_a;
      b_q   <= op_b;
    end else if (state == CALC) begin
      if (finish) begin
        result <= fin_res;
        carry  <= fin_carry;
        zero   <= (fin_res == '0);
        err    <= fin_err;
      end else begin
        acc   <= acc_nxt;
        shreg <= shreg_nxt;
        cnt   <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed table-driven bench for alu_multicycle (WIDTH=5),
// plus hand-written reset, hold and back-to-back sequences.
// Honours ALU_MC_DIV_EN the same way as the design.
module tb_alu_multicycle;
  import alu_mc_pkg::*;

  localparam int W = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [W-1:0]   op_a = '0;
  logic [W-1:0]   op_b = '0;
  logic [1:0]     op_sel = '0;
  logic           in_ready, out_valid, carry, zero, err;
  logic [2*W-1:0] result;

  int checks = 0;
  int errors = 0;

  logic [2*W-1:0] cap_res;
  logic           cap_c, cap_z, cap_e;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero), .err(err)
  );

  typedef struct {
    logic [1:0]     op;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] res;
    logic           c, z, e;
    int             lat;
    string          name;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one op, measure edges from the accept edge to out_valid, optionally
  // stall the consumer for 'hold' cycles, capture outputs, then consume.
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold, input string name, output int lat);
    int k;
    logic busy_rdy;
    @(negedge clk);
    in_valid = 1'b1; op_sel = op; op_a = a; op_b = b;
    k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    if (!in_ready) begin
      chk({name, "_accept_timeout"}, 0, 1);
      in_valid = 1'b0; lat = -1;
      return;
    end
    @(posedge clk);                      // accept edge
    @(negedge clk);
    in_valid = 1'b0; op_a = W'($urandom); op_b = W'($urandom); op_sel = 2'($urandom);
    lat = 0; busy_rdy = 1'b0;
    while (!out_valid && lat < 50) begin
      busy_rdy |= in_ready;
      @(negedge clk); lat++;
    end
    chk({name, "_in_ready_busy"}, busy_rdy, 0);
    if (!out_valid) begin
      chk({name, "_out_valid_timeout"}, 0, 1);
      return;
    end
    cap_res = result; cap_c = carry; cap_z = zero; cap_e = err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({name, "_hold_valid"}, out_valid, 1);
      chk({name, "_hold_in_ready"}, in_ready, 0);
      chk({name, "_hold_stable"}, {result, carry, zero, err}, {cap_res, cap_c, cap_z, cap_e});
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_consumed"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    int lat, idx, last_acc, n_acc, n_out;
    logic took;
    int exp_q[$];

    vecs.push_back('{OP_ADD, 5'd31, 5'd1,  10'd32, 1'b1, 1'b0, 1'b0, 1, "add_31_1"});
    vecs.push_back('{OP_ADD, 5'd0,  5'd0,  10'd0,  1'b0, 1'b1, 1'b0, 1, "add_0_0"});
    vecs.push_back('{OP_ADD, 5'd12, 5'd9,  10'd21, 1'b0, 1'b0, 1'b0, 1, "add_12_9"});
    vecs.push_back('{OP_SUB, 5'd3,  5'd5,  10'd30, 1'b1, 1'b0, 1'b0, 1, "sub_3_5"});
    vecs.push_back('{OP_SUB, 5'd7,  5'd7,  10'd0,  1'b0, 1'b1, 1'b0, 1, "sub_7_7"});
    vecs.push_back('{OP_SUB, 5'd20, 5'd6,  10'd14, 1'b0, 1'b0, 1'b0, 1, "sub_20_6"});
    vecs.push_back('{OP_MUL, 5'd7,  5'd3,  10'd21, 1'b0, 1'b0, 1'b0, 6, "mul_7_3"});
    vecs.push_back('{OP_MUL, 5'd0,  5'd13, 10'd0,  1'b0, 1'b1, 1'b0, 6, "mul_0_13"});
    vecs.push_back('{OP_MUL, 5'd16, 5'd2,  10'd32, 1'b0, 1'b0, 1'b0, 6, "mul_16_2"});
    vecs.push_back('{OP_MUL, 5'd19, 5'd27, 10'd513, 1'b0, 1'b0, 1'b0, 6, "mul_19_27"});
`ifdef ALU_MC_DIV_EN
    vecs.push_back('{OP_DIV, 5'd29, 5'd4,  10'd39,  1'b0, 1'b0, 1'b0, 6, "div_29_4"});
    vecs.push_back('{OP_DIV, 5'd9,  5'd0,  10'd319, 1'b0, 1'b0, 1'b1, 1, "div_9_0"});
    vecs.push_back('{OP_DIV, 5'd31, 5'd31, 10'd1,   1'b0, 1'b0, 1'b0, 6, "div_31_31"});
    vecs.push_back('{OP_DIV, 5'd3,  5'd7,  10'd96,  1'b0, 1'b0, 1'b0, 6, "div_3_7"});
`else
    vecs.push_back('{OP_DIV, 5'd29, 5'd4,  10'd0,   1'b0, 1'b1, 1'b1, 1, "op11_29_4"});
    vecs.push_back('{OP_DIV, 5'd9,  5'd0,  10'd0,   1'b0, 1'b1, 1'b1, 1, "op11_9_0"});
`endif

    // Reset state
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_outputs", {out_valid, result, carry, zero, err}, 0);
    @(negedge clk); rst_n = 1'b1;

    // Reset in cycle 2 of MUL 7*3 discards the operation
    @(negedge clk);
    in_valid = 1'b1; op_sel = OP_MUL; op_a = 5'd7; op_b = 5'd3;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {out_valid, result, carry, zero, err}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin seen |= out_valid; @(negedge clk); end
      chk("midrst_no_result", seen, 0);
    end
    do_op(OP_ADD, 5'd2, 5'd3, 0, "post_rst_add", lat);
    chk("post_rst_add_res", cap_res, 10'd5);
    chk("post_rst_add_lat", lat, 1);

    // Directed table
    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, vecs[i].name, lat);
      chk({vecs[i].name, "_res"},   cap_res, vecs[i].res);
      chk({vecs[i].name, "_carry"}, cap_c,   vecs[i].c);
      chk({vecs[i].name, "_zero"},  cap_z,   vecs[i].z);
      chk({vecs[i].name, "_err"},   cap_e,   vecs[i].e);
      chk({vecs[i].name, "_lat"},   lat,     vecs[i].lat);
    end

    // MUL 31*31 with the consumer stalled for 3 cycles
    do_op(OP_MUL, 5'd31, 5'd31, 3, "mul_hold", lat);
    chk("mul_hold_res", cap_res, 10'd961);
    chk("mul_hold_flags", {cap_c, cap_z, cap_e}, 3'b000);
    chk("mul_hold_lat", lat, 6);

    // Back-to-back ADDs, in_valid and out_ready held high
    idx = 0; last_acc = -1; n_acc = 0; n_out = 0;
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; op_sel = OP_ADD;
    op_a = W'(idx * 7); op_b = W'(idx * 3 + 1);
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (out_valid) begin
        n_out++;
        if (exp_q.size() == 0) chk("b2b_spurious", 1, 0);
        else chk("b2b_result", result, exp_q.pop_front());
      end
      took = in_ready;
      if (took) begin
        exp_q.push_back(int'(op_a) + int'(op_b));
        if (last_acc >= 0) chk("b2b_spacing", cyc - last_acc, 3);
        last_acc = cyc; n_acc++;
      end
      @(posedge clk);
      @(negedge clk);
      if (took) begin
        idx++;
        op_a = W'(idx * 7); op_b = W'(idx * 3 + 1);
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) begin
        n_out++;
        if (exp_q.size() == 0) chk("b2b_spurious", 1, 0);
        else chk("b2b_result", result, exp_q.pop_front());
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("b2b_count", n_out, n_acc);
    chk("b2b_min_accepts", (n_acc >= 13), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
